// File: rtl/ysyx_22050039_mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// op encodings, FSM states and the W-op iteration count.
package ysyx_22050039_mdu_pkg;

   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;
   localparam logic [3:0] OP_DIV    = 4'd4;
   localparam logic [3:0] OP_DIVU   = 4'd5;
   localparam logic [3:0] OP_REM    = 4'd6;
   localparam logic [3:0] OP_REMU   = 4'd7;
   localparam logic [3:0] OP_MULW   = 4'd8;
   localparam logic [3:0] OP_DIVW   = 4'd9;
   localparam logic [3:0] OP_DIVUW  = 4'd10;
   localparam logic [3:0] OP_REMW   = 4'd11;
   localparam logic [3:0] OP_REMUW  = 4'd12;

   // Number of iterations for the 32-bit (W) forms
   localparam int W_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ysyx_22050039_mdu_divcore.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per
// cycle. quotient_o/remainder_o present the values produced by the current
// iteration so the caller can capture the final result on the done cycle.
module ysyx_22050039_mdu_divcore
   import ysyx_22050039_mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill_i,
   input  logic            start_i,
   input  logic            w_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);
   localparam int CNT_W = $clog2(XLEN);

   logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             w_q, active_q;
   logic [XLEN:0]    shifted, diff;
   logic             ge, last;

   // One restoring step: shift in the next dividend bit, trial-subtract
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = ~diff[XLEN];
      last    = (cnt_q == (w_q ? CNT_W'(W_ITER - 1) : CNT_W'(XLEN - 1)));
   end

   assign remainder_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign quotient_o  = {quo_q[XLEN-2:0], ge};
   assign done_o      = active_q & last;

   // Load on start; W magnitudes are pre-aligned to the top so only 32 steps are needed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         w_q      <= 1'b0;
         active_q <= 1'b0;
      end else if (kill_i) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         rem_q    <= '0;
         quo_q    <= w_i ? (dividend_i << (XLEN - 32)) : dividend_i;
         dvs_q    <= divisor_i;
         cnt_q    <= '0;
         w_q      <= w_i;
         active_q <= 1'b1;
      end else if (active_q) begin
         rem_q <= remainder_o;
         quo_q <= quotient_o;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_22050039_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring
// divider sub-module, RISC-V special cases and valid/ready handshake.
module ysyx_22050039_mdu
   import ysyx_22050039_mdu_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);
   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // Sign-extend the low 32 bits to XLEN
   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] t;
      t = x << (XLEN - 32);
      return XLEN'($signed(t) >>> (XLEN - 32));
   endfunction

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*XLEN-1:0]  acc_q, mcand_q;
   logic [XLEN-1:0]    mplier_q;
   logic               is_div_q, w_q, hi_q, sel_rem_q, neg_q, rneg_q;
   logic [XLEN-1:0]    out_result_q;
   logic [TAG_W-1:0]   out_tag_q;
   logic               out_valid_q;

   logic dec_valid, dec_div, dec_s1, dec_s2, dec_w, dec_hi, dec_rem;
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, spec_res;
   logic a_neg, b_neg, div_zero, div_ovf, special, accept, div_start;
   logic [2*XLEN-1:0] acc_d, prod_d;
   logic [XLEN-1:0] mul_res_d, div_res_d, quo_fix_d, rem_fix_d;
   logic mul_last;
   logic div_done;
   logic [XLEN-1:0] div_quo, div_rem;

   // Decode the op into signedness, width and result-select controls
   always_comb begin
      dec_valid = 1'b1; dec_div = 1'b0; dec_s1 = 1'b0; dec_s2 = 1'b0;
      dec_w = 1'b0; dec_hi = 1'b0; dec_rem = 1'b0;
      case (in_op)
         OP_MUL:    ;
         OP_MULH:   begin dec_hi = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
         OP_MULHSU: begin dec_hi = 1'b1; dec_s1 = 1'b1; end
         OP_MULHU:  dec_hi = 1'b1;
         OP_DIV:    begin dec_div = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
         OP_DIVU:   dec_div = 1'b1;
         OP_REM:    begin dec_div = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
         OP_REMU:   begin dec_div = 1'b1; dec_rem = 1'b1; end
         OP_MULW:   dec_w = 1'b1;
         OP_DIVW:   begin dec_div = 1'b1; dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
         OP_DIVUW:  begin dec_div = 1'b1; dec_w = 1'b1; end
         OP_REMW:   begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
         OP_REMUW:  begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; end
         default:   dec_valid = 1'b0;
      endcase
   end

   // Operand extension, magnitudes and early-completion detection
   always_comb begin
      ext_a = dec_w ? (dec_s1 ? sext_w(in_src1) : XLEN'(in_src1[31:0])) : in_src1;
      ext_b = dec_w ? (dec_s2 ? sext_w(in_src2) : XLEN'(in_src2[31:0])) : in_src2;
      a_neg = dec_s1 & ext_a[XLEN-1];
      b_neg = dec_s2 & ext_b[XLEN-1];
      mag_a = a_neg ? -ext_a : ext_a;
      mag_b = b_neg ? -ext_b : ext_b;
      div_zero = (ext_b == '0);
      div_ovf  = dec_s1 & (dec_w ? ((ext_a[31:0] == 32'h8000_0000) && (ext_b[31:0] == 32'hFFFF_FFFF))
                                 : ((ext_a == MIN_NEG) && (ext_b == '1)));
      special  = dec_div & (div_zero | div_ovf);
      if (div_zero) spec_res = dec_rem ? ext_a : '1;
      else          spec_res = dec_rem ? '0 : ext_a;
      if (dec_w) spec_res = sext_w(spec_res);
   end

   assign accept    = in_valid & (state_q == ST_IDLE);
   assign div_start = accept & ~flush & dec_valid & dec_div & ~special;

   // Shift-add step and final sign fix-up for multiply and divide results
   always_comb begin
      acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod_d    = neg_q ? -acc_d : acc_d;
      mul_res_d = w_q ? sext_w(prod_d[XLEN-1:0])
                      : (hi_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0]);
      mul_last  = (cnt_q == (w_q ? CNT_W'(W_ITER - 1) : CNT_W'(XLEN - 1)));
      quo_fix_d = neg_q ? -div_quo : div_quo;
      rem_fix_d = rneg_q ? -div_rem : div_rem;
      div_res_d = sel_rem_q ? rem_fix_d : quo_fix_d;
      if (w_q) div_res_d = sext_w(div_res_d);
   end

   ysyx_22050039_mdu_divcore #(.XLEN(XLEN)) u_divcore (
      .clk         (clk),
      .rst         (rst),
      .kill_i      (flush),
      .start_i     (div_start),
      .w_i         (dec_w),
      .dividend_i  (mag_a),
      .divisor_i   (mag_b),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   // Control FSM with registered outputs; flush overrides everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         is_div_q     <= 1'b0;
         w_q          <= 1'b0;
         hi_q         <= 1'b0;
         sel_rem_q    <= 1'b0;
         neg_q        <= 1'b0;
         rneg_q       <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         out_valid_q  <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) begin
               out_tag_q <= in_tag;
               is_div_q  <= dec_div;
               w_q       <= dec_w;
               hi_q      <= dec_hi;
               sel_rem_q <= dec_rem;
               neg_q     <= a_neg ^ b_neg;
               rneg_q    <= a_neg;
               cnt_q     <= '0;
               acc_q     <= '0;
               mcand_q   <= {{XLEN{1'b0}}, mag_a};
               mplier_q  <= mag_b;
               if (!dec_valid) begin
                  out_result_q <= '0;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_DONE;
               end else if (special) begin
                  out_result_q <= spec_res;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_DONE;
               end else begin
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (is_div_q) begin
                  if (div_done) begin
                     out_result_q <= div_res_d;
                     out_valid_q  <= 1'b1;
                     state_q      <= ST_DONE;
                  end
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + CNT_W'(1);
                  if (mul_last) begin
                     out_result_q <= mul_res_d;
                     out_valid_q  <= 1'b1;
                     state_q      <= ST_DONE;
                  end
               end
            end
            ST_DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_ysyx_22050039_mdu.sv
// Self-checking bench for the multiply/divide unit: directed vectors,
// randomized ops against an arithmetic reference model, backpressure,
// flush and asynchronous reset mid-operation.
module tb_ysyx_22050039_mdu;
   import ysyx_22050039_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  in_op;
   logic [63:0] in_src1, in_src2, out_result;
   logic [4:0]  in_tag, out_tag;
   int          n_checks = 0;
   int          n_fail = 0;

   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   always #5 clk = ~clk;

   ysyx_22050039_mdu #(.XLEN(64), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   // Reference: RISC-V M semantics computed with plain wide arithmetic
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] pa, pb, p;
      logic [127:0] up;
      longint sa, sb;
      int sa32, sb32;
      logic [31:0] r32;
      sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
      case (op)
         OP_MUL:    return a * b;
         OP_MULH:   begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
         OP_MULHSU: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
         OP_MULHU:  begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
         OP_DIV:    begin
            if (b == 0) return '1;
            if (a == MINV && b == '1) return a;
            return sa / sb;
         end
         OP_DIVU:   return (b == 0) ? '1 : a / b;
         OP_REM:    begin
            if (b == 0) return a;
            if (a == MINV && b == '1) return 64'd0;
            return sa % sb;
         end
         OP_REMU:   return (b == 0) ? a : a % b;
         OP_MULW:   r32 = a[31:0] * b[31:0];
         OP_DIVW:   begin
            if (sb32 == 0) r32 = '1;
            else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
            else r32 = sa32 / sb32;
         end
         OP_DIVUW:  r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
         OP_REMW:   begin
            if (sb32 == 0) r32 = a[31:0];
            else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
            else r32 = sa32 % sb32;
         end
         OP_REMUW:  r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
         default:   return 64'd0;
      endcase
      return {{32{r32[31]}}, r32};
   endfunction

   // Expected cycles from accept to out_valid
   function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      bit w, dv, sg, zero, ovf;
      w  = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
      dv = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
      sg = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
      if (op > OP_REMUW) return 1;
      zero = w ? (b[31:0] == 0) : (b == 0);
      ovf  = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MINV && b == '1));
      if (dv && (zero || ovf)) return 1;
      return w ? 32 : 64;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 6))
         0: return 64'd0;
         1: return '1;
         2: return MINV;
         3: return 64'($urandom_range(0, 20));
         4: return {32'($urandom), 32'h8000_0000};
         5: return 64'd0 - 64'($urandom_range(1, 20));
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Issue one op, wait (bounded) for out_valid, optionally complete the output handshake
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input bit release_out,
                         output logic [63:0] res, output logic [4:0] rtag, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op = 4'($urandom); in_src1 = {32'($urandom), 32'($urandom)};
      in_src2 = {32'($urandom), 32'($urandom)}; in_tag = 5'($urandom);
      lat = 0;
      forever begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid || lat >= 300) break;
      end
      res = out_result;
      rtag = out_tag;
      if (release_out) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_checks++; if (out_result !== 64'd0) begin n_fail++; $display("FAIL reset_out_result got=%h want=0", out_result); end
      n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag got=%0d want=0", out_tag); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   typedef struct { logic [3:0] op; logic [63:0] a, b, expv; int lat; } vec_t;

   task automatic test_directed();
      vec_t v[11];
      logic [63:0] res; logic [4:0] rt; int lat;
      v[0]  = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64};
      v[1]  = '{OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64};
      v[2]  = '{OP_DIVU,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      v[3]  = '{OP_REMU,  64'h1234, 64'd0, 64'h1234, 1};
      v[4]  = '{OP_DIV,   MINV, 64'hFFFF_FFFF_FFFF_FFFF, MINV, 1};
      v[5]  = '{OP_REM,   MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      v[6]  = '{OP_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      v[7]  = '{OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64};
      v[8]  = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
      v[9]  = '{OP_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32};
      v[10] = '{4'd13,    64'h55, 64'h66, 64'd0, 1};
      for (int i = 0; i < 11; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), 1'b1, res, rt, lat);
         $display("directed %0d op=%0d a=%h b=%h res=%h lat=%0d", i, v[i].op, v[i].a, v[i].b, res, lat);
         n_checks++; if (res !== v[i].expv) begin n_fail++; $display("FAIL directed_%0d_result got=%h want=%h", i, res, v[i].expv); end
         n_checks++; if (lat != v[i].lat) begin n_fail++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
         n_checks++; if (rt !== 5'(i + 1)) begin n_fail++; $display("FAIL directed_%0d_tag got=%0d want=%0d", i, rt, i + 1); end
      end
   endtask

   task automatic test_random();
      logic [3:0] op; logic [63:0] a, b, expv, res; logic [4:0] tag, rt; int lat, el;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15)); a = pick(); b = pick(); tag = 5'($urandom);
         expv = ref_model(op, a, b); el = exp_lat(op, a, b);
         run_op(op, a, b, tag, 1'b1, res, rt, lat);
         $display("random %0d op=%0d a=%h b=%h res=%h tag=%0d lat=%0d", i, op, a, b, res, rt, lat);
         n_checks++; if (res !== expv) begin n_fail++; $display("FAIL random_%0d_result op=%0d got=%h want=%h", i, op, res, expv); end
         n_checks++; if (lat != el) begin n_fail++; $display("FAIL random_%0d_latency op=%0d got=%0d want=%0d", i, op, lat, el); end
         n_checks++; if (rt !== tag) begin n_fail++; $display("FAIL random_%0d_tag got=%0d want=%0d", i, rt, tag); end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] res; logic [4:0] rt; int lat;
      run_op(OP_DIVU, 64'd100, 64'd7, 5'd17, 1'b0, res, rt, lat);
      $display("backpressure res=%h tag=%0d lat=%0d", res, rt, lat);
      n_checks++; if (res !== 64'd14) begin n_fail++; $display("FAIL bp_result got=%h want=%h", res, 64'd14); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid_%0d got=%b want=1", c, out_valid); end
         n_checks++; if (out_result !== 64'd14) begin n_fail++; $display("FAIL bp_hold_result_%0d got=%h want=%h", c, out_result, 64'd14); end
         n_checks++; if (out_tag !== 5'd17) begin n_fail++; $display("FAIL bp_hold_tag_%0d got=%0d want=17", c, out_tag); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready_%0d got=%b want=0", c, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_flush();
      logic [63:0] res; logic [4:0] rt; int lat, seen;
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_MUL; in_src1 = 64'd1234; in_src2 = 64'd5678; in_tag = 5'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
      seen = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_result got=%0d want=0 valid cycles", seen); end
      run_op(OP_MUL, 64'd3, 64'd5, 5'd4, 1'b1, res, rt, lat);
      $display("after flush MUL 3x5 res=%h lat=%0d", res, lat);
      n_checks++; if (res !== 64'd15) begin n_fail++; $display("FAIL flush_then_mul got=%h want=%h", res, 64'd15); end
      n_checks++; if (lat != 64) begin n_fail++; $display("FAIL flush_then_mul_latency got=%0d want=64", lat); end
   endtask

   task automatic test_rst_mid();
      logic [63:0] res; logic [4:0] rt; int lat;
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_DIV; in_src1 = 64'd999; in_src2 = 64'd7; in_tag = 5'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
      n_checks++; if (out_result !== 64'd0) begin n_fail++; $display("FAIL rst_mid_out_result got=%h want=0", out_result); end
      n_checks++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL rst_mid_out_tag got=%0d want=0", out_tag); end
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_REMU, 64'd100, 64'd7, 5'd6, 1'b1, res, rt, lat);
      $display("after reset REMU 100%%7 res=%h lat=%0d", res, lat);
      n_checks++; if (res !== 64'd2) begin n_fail++; $display("FAIL rst_then_remu got=%h want=%h", res, 64'd2); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_flush();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22050039_mdu.md
# ysyx_22050039_mdu

Iterative RV64M multiply/divide unit. It executes the MUL/DIV/REM families, including the W-suffixed forms, as multi-cycle operations behind a valid/ready handshake. It sits beside the single-cycle execute datapath: decode dispatches M-extension ops here, and results return to writeback tagged with their destination register. Width and tag size are parametrised. Divide-by-zero and signed overflow follow RISC-V semantics and complete early.

## Interface
- XLEN, 64, datapath width; must be even and ≥ 32
- TAG_W, 5, width of the passthrough tag (rd index)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  abort current op, synchronous
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  4  operation code, from the shared package
- in_src1  in  XLEN  rs1 value (dividend / multiplicand)
- in_src2  in  XLEN  rs2 value (divisor / multiplier)
- in_tag  in  TAG_W  carried to out_tag unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  final, sign-extended result
- out_tag  out  TAG_W  tag of the op that produced out_result

## Operation
- Ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- Undefined op codes: complete in 1 cycle with result 0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). The accepting edge is in_valid & in_ready.
- On accept, the unit latches operands, op and tag.
- W ops use src[31:0]: sign-extended for signed ops, zero-extended for unsigned ops.
- Iteration count N: XLEN for full-width ops, 32 for W ops.
- Multiply: shift-add, one multiplier bit per BUSY cycle, 2·XLEN-bit accumulator.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half, with signed/unsigned operand handling per op.
- Divide: radix-2 restoring on magnitudes, one quotient bit per BUSY cycle.
  - Sign fix-up is applied on the edge that enters DONE.
  - Quotient sign = sign1 XOR sign2. Remainder sign = dividend sign.
- Special cases go IDLE→DONE on the accepting edge:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
  - Detection uses the 32-bit operands for W ops.
- W results: the 32-bit result is sign-extended to XLEN (this includes DIVUW and REMUW).
- DONE: out_valid=1. out_result and out_tag are held stable until out_valid & out_ready, then the FSM returns to IDLE.
- flush (any state): next state IDLE, out_valid 0, result discarded. flush has priority over a coincident accept or out handshake.
- Reset values: state IDLE, out_valid 0, in_ready 1 once rst deasserts, out_result 0, out_tag 0, iteration counter 0. Reset mid-op discards the op.

## Timing
- Normal op: accept at edge E0. BUSY iterations occur on edges E1..EN. out_valid is high from edge EN.
  - Full-width ops: 64-cycle latency at XLEN=64.
  - W ops: 32-cycle latency.
- Special case and undefined op: out_valid is high from edge E1.
- Throughput: one op in flight. in_ready is low from the accepting edge until the cycle after the output handshake, so there is no back-to-back accept in the same cycle as an output handshake.
- in_src*, in_op and in_tag may change after acceptance without effect on the op in flight.
- No combinational path from in_valid or out_ready to any output.

## Structure
- Package ysyx_22050039_mdu_pkg holds:
  - op encoding localparams
  - FSM state enum
  - the W-op iteration constant 32
- One sub-module, ysyx_22050039_mdu_divcore, holds the restoring-divide iteration:
  - registers: remainder/quotient shift register
  - ports: start, width select, magnitudes, done
- Multiply, sign handling, special-case detection and handshake live in the top.

## Test plan
- DIV −7/2 (src1=0xFFFF_FFFF_FFFF_FFF9, src2=2) → out_result 0xFFFF_FFFF_FFFF_FFFD after 64 cycles. REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 0x1234/0 → 0xFFFF_FFFF_FFFF_FFFF, and REMU 0x1234/0 → 0x1234, each with out_valid one cycle after accept.
- Signed overflow:
  - DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000.
  - REM on the same operands → 0.
  - DIVW 0x8000_0000/0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Multiply, each at the stated latency (64 cycles full-width, 32 cycles for MULW):
  - MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
  - MUL all-ones × all-ones → 1.
  - MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: out_ready held low for 5 cycles in DONE with tag=17. out_valid, out_result and out_tag=17 stay stable and in_ready stays 0. The FSM returns to IDLE the cycle after out_ready=1.
- Abort:
  - flush asserted at BUSY iteration 10 → IDLE next cycle, no out_valid. A new MUL 3×5 is then accepted and yields 15.
  - Async rst pulsed mid-BUSY → outputs read their reset values immediately.
